mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external memory bus between instruction fetch (F stage) and load/store (M stage).
//  Three-state FSM: grants, holds address/control stable until ack, returns data/ack to the winner.
//  Placed between datapath/controller and the top-level pins; drives the DDT tri-state enable.
//  Data port has fixed priority over fetch, because the older instruction must complete first.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles a granted access waits for ack (used only with ARB_TIMEOUT_EN); 1..65535
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   reset, asynchronous, active-high
//  i_req        in   1   fetch request; held high until i_ack
//  i_addr       in   32  fetch address (PC)
//  i_rdata      out  32  fetched instruction, valid while i_ack=1
//  i_ack        out  1   fetch done, one cycle; combinational from bus_ack_n
//  d_req        in   1   load/store request; held high until d_ack
//  d_write      in   1   1=store, 0=load
//  d_size       in   2   00 byte, 01 half, 10 word
//  d_addr       in   32  data address
//  d_wdata      in   32  store data
//  d_rdata      out  32  load data, valid while d_ack=1
//  d_ack        out  1   data access done, one cycle; combinational from bus_ack_n
//  bus_addr     out  32  shared bus address
//  bus_mreq     out  1   bus request, high for the whole granted access
//  bus_write    out  1   bus write strobe
//  bus_size     out  2   bus access size
//  bus_wdata    out  32  bus write data
//  bus_wen      out  1   DDT drive enable (= bus_write)
//  bus_rdata    in   32  bus read data
//  bus_ack_n    in   1   bus ack, active-low
//  bus_err      out  1   timeout pulse, one cycle (constant 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  States: IDLE, IACC, DACC. Grant registered.
//  - IDLE: d_req=1 -> DACC; else i_req=1 -> IACC; else stay.
//    On grant, latch addr/size/write/wdata of the winner.
//  - IACC/DACC: bus_mreq=1; bus_* come only from latched registers, stable until ack.
//    bus_ack_n=0 sampled -> winner ack=1 in that same cycle, rdata=bus_rdata (pass-through); next state IDLE.
//  - IACC drives bus_size=2'b10, bus_write=0, bus_wdata=0.
//    DACC drives the latched d_size/d_write/d_wdata.
//  - Timing: request seen at edge N -> bus_mreq from cycle N+1.
//    Zero-wait ack gives a 2-cycle access. One mandatory IDLE cycle separates accesses,
//    so a still-high req from a just-acked requester is never re-granted.
//  - Both requests in IDLE -> DACC; fetch is granted in the IDLE after the data ack.
//  - Request arriving while the bus is busy -> waits; no preemption.
//  - bus_ack_n=0 in IDLE -> ignored; no ack output.
//  - Requester drops req mid-access -> access still completes; ack still pulses.
//  - Changes to i_addr/d_addr while granted -> no effect on the bus (latched).
//  - i_ack and d_ack are never high in the same cycle.
//  - Reset values (immediate on rst, async): state IDLE; bus_mreq/bus_write/bus_wen/bus_err=0;
//    bus_addr/bus_wdata=0; bus_size=00; i_ack/d_ack=0; i_rdata/d_rdata=0.
//    rst mid-access aborts it silently; no ack is issued.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//  - 16-bit wait counter clears on grant and increments each busy cycle without ack.
//  - When it reaches TIMEOUT_CYCLES with no ack: bus_err=1 for one cycle and the winner's ack=1
//    with rdata=32'h0000_0013 (NOP). Next state IDLE.
//  - Ack in the same cycle as the limit -> normal completion; no bus_err.
//  ARB_TIMEOUT_EN undefined: no counter; a busy state waits for ack indefinitely; bus_err tied 0.
// TESTING
//  1. i_req=1, i_addr=0x100, ack_n low on first bus cycle -> bus_mreq cycle 1, bus_addr=0x100,
//     bus_size=10; i_ack cycle 1 with bus data 0x00A00093.
//  2. i_req and d_req (store, addr 0x2000, wdata 0xDEADBEEF, size 00) together -> DACC first:
//     bus_write=1, bus_wen=1, bus_size=00; d_ack; IDLE; then IACC.
//  3. Load granted, ack delayed 5 cycles, d_addr changed mid-wait -> bus_addr stays at the original
//     value; d_ack in cycle 6 only; i_ack stays 0.
//  4. rst pulsed during DACC with ack pending -> bus_mreq=0 immediately; no d_ack;
//     the next grant follows the normal IDLE rules.
//  5. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never arrives -> bus_err and i_ack in busy cycle 4,
//     i_rdata=0x00000013, then IDLE. Without the macro: bus_mreq held for 100+ cycles, bus_err=0.
//  6. bus_ack_n low while IDLE with no requests -> no ack; state stays IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter sharing one external memory bus between fetch and load/store.
// Optional macro ARB_TIMEOUT_EN adds a wait-cycle limit that completes a stuck access with a NOP and bus_err.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [31:0] bus_addr,
    output logic        bus_mreq,
    output logic        bus_write,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_wdata,
    output logic        bus_wen,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack_n,
    output logic        bus_err,
    output logic [1:0]  arb_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    state_t      state;
    state_t      state_next;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_write;
    logic        busy;
    logic        ack_hit;
    logic        timeout;
    logic        done;
    logic [31:0] resp_data;

    assign busy    = (state != IDLE);
    assign ack_hit = busy && !bus_ack_n;
    assign done    = ack_hit || timeout;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;

    // Counter holds the number of completed busy cycles, so busy cycle k sees k-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 16'd0;
        end else if (!busy) begin
            wait_cnt <= 16'd0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout = busy && bus_ack_n && (wait_cnt == LIMIT);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (d_req) begin
                    state_next = DACC;
                end else if (i_req) begin
                    state_next = IACC;
                end
            end
            IACC, DACC: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The winner's request is captured once at grant; the bus only ever sees these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_size  <= 2'b00;
            lat_write <= 1'b0;
        end else if (state == IDLE) begin
            if (d_req) begin
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                lat_size  <= d_size;
                lat_write <= d_write;
            end else if (i_req) begin
                lat_addr  <= i_addr;
                lat_wdata <= 32'd0;
                lat_size  <= 2'b10;
                lat_write <= 1'b0;
            end
        end
    end

    assign bus_mreq  = busy;
    assign bus_addr  = lat_addr;
    assign bus_size  = lat_size;
    assign bus_wdata = lat_wdata;
    assign bus_write = busy && lat_write;
    assign bus_wen   = bus_write;
    assign bus_err   = timeout;

    assign resp_data = timeout ? NOP_INSN : bus_rdata;
    assign i_ack     = (state == IACC) && done;
    assign d_ack     = (state == DACC) && done;
    assign i_rdata   = i_ack ? resp_data : 32'd0;
    assign d_rdata   = d_ack ? resp_data : 32'd0;
    assign arb_state = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table-driven accesses plus hand-written grant, reset and timeout sequences.
// A per-cycle monitor compares bus fields and acks against expected queues filled when requests are driven.
module tb_mem_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
    localparam int LONG_DELAY = 3;
`else
    localparam int TO = 255;
    localparam int LONG_DELAY = 5;
`endif
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IACC = 2'd1;
    localparam logic [1:0] S_DACC = 2'd2;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] bus_addr;
    logic        bus_mreq;
    logic        bus_write;
    logic [1:0]  bus_size;
    logic [31:0] bus_wdata;
    logic        bus_wen;
    logic [31:0] bus_rdata;
    logic        bus_ack_n;
    logic        bus_err;
    logic [1:0]  arb_state;

    mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .bus_addr(bus_addr), .bus_mreq(bus_mreq), .bus_write(bus_write),
        .bus_size(bus_size), .bus_wdata(bus_wdata), .bus_wen(bus_wen),
        .bus_rdata(bus_rdata), .bus_ack_n(bus_ack_n), .bus_err(bus_err),
        .arb_state(arb_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic [1:0]  exp_size;
        logic        exp_write;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t        vecs[7];
    logic [66:0] exp_bus_q[$];
    logic [32:0] exp_ack_q[$];

    int          checks = 0;
    int          failures = 0;
    logic        mreq_prev = 1'b0;
    logic [66:0] cur_bus = '0;
    int          busy_cnt = 0;
    int          ack_delay = 0;
    int          ack_cycle = 0;
    logic [31:0] resp_data = '0;
    logic        idle_ack_n = 1'b1;
    logic        i_ack_seen = 1'b0;
    logic        d_ack_seen = 1'b0;

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic        timeout_now;
        logic        exp_ack;
        logic [32:0] a;
        timeout_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
        timeout_now = bus_mreq && bus_ack_n && (busy_cnt == TO);
`endif
        exp_ack = bus_mreq && (!bus_ack_n || timeout_now);
        check("ack_pulse", {65'd0, i_ack | d_ack}, {65'd0, exp_ack});
        check("ack_exclusive", {66'd0, i_ack & d_ack}, 67'd0);
        check("bus_err", {66'd0, bus_err}, {66'd0, timeout_now});
        check("bus_wen", {66'd0, bus_wen}, {66'd0, bus_write});
        if (bus_mreq && !mreq_prev) begin
            if (exp_bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant: got grant addr %0h expected no grant", bus_addr);
            end else begin
                cur_bus = exp_bus_q.pop_front();
            end
        end
        if (bus_mreq) check("bus_fields", {bus_addr, bus_size, bus_write, bus_wdata}, cur_bus);
        else check("idle_write", {66'd0, bus_write}, 67'd0);
        if (i_ack || d_ack) begin
            if (exp_ack_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: got i_ack=%0b d_ack=%0b expected none", i_ack, d_ack);
            end else begin
                a = exp_ack_q.pop_front();
                check("ack_data", {34'd0, d_ack, d_ack ? d_rdata : i_rdata}, {34'd0, a});
            end
            ack_cycle = busy_cnt;
            i_ack_seen = i_ack_seen | i_ack;
            d_ack_seen = d_ack_seen | d_ack;
        end
        mreq_prev = bus_mreq;
    endtask

    // One clock: requesters drop after their ack, the bus model answers, then outputs are checked.
    task automatic tick();
        @(posedge clk);
        #1;
        if (i_ack_seen) begin
            i_req = 1'b0;
            i_ack_seen = 1'b0;
        end
        if (d_ack_seen) begin
            d_req = 1'b0;
            d_ack_seen = 1'b0;
        end
        if (bus_mreq) begin
            busy_cnt++;
            bus_ack_n = ((busy_cnt - 1) == ack_delay) ? 1'b0 : 1'b1;
        end else begin
            busy_cnt = 0;
            bus_ack_n = idle_ack_n;
        end
        bus_rdata = resp_data;
        @(negedge clk);
        monitor();
    endtask

    task automatic issue(input vec_t v);
        if (v.is_data) begin
            d_req = 1'b1;
            d_write = v.write;
            d_size = v.size;
            d_addr = v.addr;
            d_wdata = v.wdata;
        end else begin
            i_req = 1'b1;
            i_addr = v.addr;
        end
        ack_delay = v.delay;
        resp_data = v.rdata;
        exp_bus_q.push_back({v.addr, v.exp_size, v.exp_write, v.exp_wdata});
        exp_ack_q.push_back({v.is_data, v.rdata});
    endtask

    task automatic wait_done(input int max_cycles);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            tick();
            if (exp_ack_q.size() == 0 && !bus_mreq && !i_req && !d_req) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_done: got %0d acks outstanding after %0d cycles expected 0",
                     exp_ack_q.size(), max_cycles);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vd;
        vec_t vf;
        vecs[0] = '{1'b0, 1'b0, 2'b00, 32'h0000_0100, 32'h0, 32'h00A0_0093, 0, 2'b10, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h5A5A_5A5A, 32'h1111_2222, 0, 2'b10, 1'b0, 32'h5A5A_5A5A};
        vecs[2] = '{1'b1, 1'b1, 2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1, 2'b01, 1'b1, 32'h0000_BEEF};
        vecs[3] = '{1'b0, 1'b0, 2'b00, 32'h0000_0104, 32'h0, 32'h0010_0113, 2, 2'b10, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 2'b00, 32'h0000_0003, 32'hFFFF_FFA5, 32'h0, 3, 2'b00, 1'b1, 32'hFFFF_FFA5};
        vecs[5] = '{1'b1, 1'b0, 2'b00, 32'h0000_0007, 32'h0, 32'h0000_0080, 1, 2'b00, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 3, 2'b10, 1'b0, 32'h0};

        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_write = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
        bus_rdata = '0; bus_ack_n = 1'b1;
        #3;
        check("reset_ctrl", {59'd0, bus_mreq, bus_write, bus_wen, bus_err, i_ack, d_ack, arb_state}, 67'd0);
        check("reset_bus", {bus_addr, bus_size, 1'b0, bus_wdata}, 67'd0);
        check("reset_rdata", {3'd0, i_rdata, d_rdata}, 67'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single fetch with a zero-wait ack: grant in cycle 1, ack in the same cycle.
        issue(vecs[0]);
        check("t1_mreq_before", {66'd0, bus_mreq}, 67'd0);
        tick();
        check("t1_mreq_c1", {66'd0, bus_mreq}, 67'd1);
        check("t1_iack_c1", {66'd0, i_ack}, 67'd1);
        check("t1_rdata", {35'd0, i_rdata}, {35'd0, 32'h00A0_0093});
        check("t1_addr_size", {33'd0, bus_addr, bus_size}, {33'd0, 32'h0000_0100, 2'b10});
        tick();
        check("t1_idle_gap", {64'd0, bus_mreq, arb_state}, {64'd0, 1'b0, S_IDLE});
        wait_done(10);

        for (int i = 1; i < 7; i++) begin
            issue(vecs[i]);
            wait_done(40);
        end

        // Simultaneous requests: data wins, fetch follows after one idle cycle.
        vd = '{1'b1, 1'b1, 2'b00, 32'h0000_2000, 32'hDEAD_BEEF, 32'h1234_5678, 0, 2'b00, 1'b1, 32'hDEAD_BEEF};
        vf = '{1'b0, 1'b0, 2'b00, 32'h0000_0200, 32'h0, 32'h1234_5678, 0, 2'b10, 1'b0, 32'h0};
        issue(vd);
        issue(vf);
        tick();
        check("t2_dacc", {62'd0, arb_state, bus_write, bus_wen, d_ack}, {62'd0, S_DACC, 3'b111});
        check("t2_size", {65'd0, bus_size}, 67'd0);
        tick();
        check("t2_idle", {64'd0, bus_mreq, arb_state}, {64'd0, 1'b0, S_IDLE});
        tick();
        check("t2_iacc", {64'd0, arb_state, i_ack}, {64'd0, S_IACC, 1'b1});
        wait_done(10);

        // A data request arriving during a fetch waits for it.
        vf = '{1'b0, 1'b0, 2'b00, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 3, 2'b10, 1'b0, 32'h0};
        vd = '{1'b1, 1'b0, 2'b01, 32'h0000_0404, 32'h0000_0001, 32'h0BAD_F00D, 3, 2'b01, 1'b0, 32'h0000_0001};
        issue(vf);
        tick();
        issue(vd);
        tick();
        check("nopreempt_state", {65'd0, arb_state}, {65'd0, S_IACC});
        wait_done(30);

        // Delayed load with request fields changing mid-wait.
        vd = '{1'b1, 1'b0, 2'b10, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, LONG_DELAY, 2'b10, 1'b0, 32'h0};
        issue(vd);
        tick();
        tick();
        d_addr = 32'h5555_0000;
        d_size = 2'b00;
        d_write = 1'b1;
        d_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (d_ack) break;
        end
        check("t3_ack_cycle", {35'd0, ack_cycle}, {35'd0, LONG_DELAY + 1});
        check("t3_no_iack", {66'd0, i_ack}, 67'd0);
        wait_done(10);

        // Reset in the middle of a pending data access.
        vd = '{1'b1, 1'b0, 2'b10, 32'h0000_6000, 32'h0, 32'h7777_7777, 1000, 2'b10, 1'b0, 32'h0};
        issue(vd);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t4_mreq", {66'd0, bus_mreq}, 67'd0);
        check("t4_no_ack", {64'd0, d_ack, arb_state}, 67'd0);
        check("t4_addr", {35'd0, bus_addr}, 67'd0);
        d_req = 1'b0;
        exp_bus_q.delete();
        exp_ack_q.delete();
        mreq_prev = 1'b0;
        busy_cnt = 0;
        i_ack_seen = 1'b0;
        d_ack_seen = 1'b0;
        @(negedge clk);
        check("t4_no_ack_rst", {66'd0, d_ack}, 67'd0);
        rst = 1'b0;
        vf = '{1'b0, 1'b0, 2'b00, 32'h0000_0700, 32'h0, 32'h0000_0713, 0, 2'b10, 1'b0, 32'h0};
        issue(vf);
        tick();
        check("t4_regrant", {65'd0, arb_state}, {65'd0, S_IACC});
        wait_done(10);

        // Ack strobe while idle must be ignored.
        idle_ack_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_idle", {64'd0, arb_state, i_ack | d_ack}, 67'd0);
        end
        idle_ack_n = 1'b1;
        tick();

        // Access whose ack never comes.
        vf = '{1'b0, 1'b0, 2'b00, 32'h0000_0800, 32'h0, 32'hBAD0_BAD0, 100000, 2'b10, 1'b0, 32'h0};
        issue(vf);
`ifdef ARB_TIMEOUT_EN
        void'(exp_ack_q.pop_back());
        exp_ack_q.push_back({1'b0, 32'h0000_0013});
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i_ack) break;
        end
        check("t5_to_cycle", {35'd0, ack_cycle}, {35'd0, TO});
        check("t5_to_err", {64'd0, bus_err, i_ack, d_ack}, {64'd0, 3'b110});
        check("t5_to_rdata", {35'd0, i_rdata}, {35'd0, 32'h0000_0013});
        tick();
        check("t5_to_idle", {65'd0, arb_state}, {65'd0, S_IDLE});
        wait_done(10);
`else
        for (int i = 0; i < 120; i++) begin
            tick();
        end
        check("t5_hold_mreq", {65'd0, bus_mreq, bus_err}, {65'd0, 2'b10});
        check("t5_hold_state", {65'd0, arb_state}, {65'd0, S_IACC});
        ack_delay = busy_cnt;
        wait_done(10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
